// File: rtl/wb_mux_n.sv
// Registered Wishbone 1-to-N address decoder/mux. It latches one slave per transaction.
// Unmapped addresses and slaves that never ack get an ERR_DATA error ack, so the master bus cannot hang.
module wb_mux_n #(
  parameter int                     N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0] MATCH_ADDR     = {32'h30003000, 32'h30002000,
                                                      32'h30001000, 32'h30000000},
  parameter logic [N_SLAVES*32-1:0] MATCH_MASK     = {N_SLAVES{32'hFFFFF000}},
  parameter int                     TIMEOUT_CYCLES = 255,
  parameter logic [31:0]            ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [31:0]              io_wbs_adr,
  input  logic [31:0]              io_wbs_datwr,
  output logic [31:0]              io_wbs_datrd,
  input  logic                     io_wbs_we,
  input  logic [3:0]               io_wbs_sel,
  input  logic                     io_wbs_stb,
  input  logic                     io_wbs_cyc,
  output logic                     io_wbs_ack,
  output logic [N_SLAVES*32-1:0]   io_wbs_adr_s,
  output logic [N_SLAVES*32-1:0]   io_wbs_datwr_s,
  input  logic [N_SLAVES*32-1:0]   io_wbs_datrd_s,
  output logic [N_SLAVES-1:0]      io_wbs_we_s,
  output logic [N_SLAVES*4-1:0]    io_wbs_sel_s,
  output logic [N_SLAVES-1:0]      io_wbs_stb_s,
  input  logic [N_SLAVES-1:0]      io_wbs_ack_s,
  output logic [N_SLAVES-1:0]      io_wbs_cyc_s,
  output logic                     err_o,
  output logic [1:0]               dbg_state
);

  // Handshake: the master request is cyc&stb held until io_wbs_ack. Toward the slaves,
  // stb_s/cyc_s stay high for the selected slave only, until its ack, a timeout, or a master abort.
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RESP = 2'd2} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [N_SLAVES-1:0]   hit_oh, slv_q;
  logic                  hit;
  logic [31:0]           adr_q, dat_q, datrd_q, sel_dat;
  logic                  we_q, err_q, sel_ack, timeout;
  logic [3:0]            sel_q;
  logic [TW-1:0]         timer_q;

  // The scan runs upward and stops at the first match, so the lowest index wins an overlap.
  always_comb begin
    hit_oh = '0;
    hit    = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit && ((io_wbs_adr & MATCH_MASK[i*32 +: 32]) == MATCH_ADDR[i*32 +: 32])) begin
        hit_oh[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  // Only the latched slave's ack and data are seen; the others are masked off.
  always_comb begin
    sel_ack = |(io_wbs_ack_s & slv_q);
    sel_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (slv_q[i]) sel_dat = sel_dat | io_wbs_datrd_s[i*32 +: 32];
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (timer_q == T_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io_wbs_cyc && io_wbs_stb) state_d = hit ? ACTIVE : RESP;
      ACTIVE:  if (!io_wbs_cyc)              state_d = IDLE;
               else if (sel_ack || timeout)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_wbs_stb_s = (state_q == ACTIVE) ? slv_q : '0;
    io_wbs_cyc_s = (state_q == ACTIVE) ? slv_q : '0;
    io_wbs_ack   = (state_q == RESP);
    err_o        = (state_q == RESP) && err_q;
    dbg_state    = state_q;
  end

  // io_wbs_datrd is loaded on entry to RESP. It is held afterwards, so it also works as the response register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      slv_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      datrd_q <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (io_wbs_cyc && io_wbs_stb) begin
          if (hit) begin
            slv_q   <= hit_oh;
            adr_q   <= io_wbs_adr;
            dat_q   <= io_wbs_datwr;
            we_q    <= io_wbs_we;
            sel_q   <= io_wbs_sel;
            timer_q <= '0;
          end else begin
            datrd_q <= ERR_DATA;
            err_q   <= 1'b1;
          end
        end
        ACTIVE: begin
          timer_q <= timer_q + TW'(1);
          if (io_wbs_cyc) begin
            if (sel_ack) begin
              datrd_q <= sel_dat;
              err_q   <= 1'b0;
            end else if (timeout) begin
              datrd_q <= ERR_DATA;
              err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_wbs_datrd   = datrd_q;
  assign io_wbs_adr_s   = {N_SLAVES{adr_q}};
  assign io_wbs_datwr_s = {N_SLAVES{dat_q}};
  assign io_wbs_we_s    = {N_SLAVES{we_q}};
  assign io_wbs_sel_s   = {N_SLAVES{sel_q}};

endmodule

// File: tb/tb_wb_mux_n.sv
// Directed bench for wb_mux_n: normal read/write, unmapped access, timeout, overlap, reset and abort.
// Inputs are driven and outputs are checked on the falling clock edge.
module tb_wb_mux_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  adr, datwr;
  logic         we;
  logic [3:0]   sel;
  logic         cyc_a, stb_a, cyc_b, stb_b;

  logic [31:0]  datrd_a, datrd_b;
  logic         ack_a, ack_b, err_a, err_b;
  logic [127:0] adr_s_a, datwr_s_a, datrd_s_a, adr_s_b, datwr_s_b, datrd_s_b;
  logic [3:0]   we_s_a, stb_s_a, cyc_s_a, ack_s_a, we_s_b, stb_s_b, cyc_s_b, ack_s_b;
  logic [15:0]  sel_s_a, sel_s_b;
  logic [1:0]   st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_mux_n #(.N_SLAVES(4), .TIMEOUT_CYCLES(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .io_wbs_adr(adr), .io_wbs_datwr(datwr), .io_wbs_datrd(datrd_a),
    .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb_a), .io_wbs_cyc(cyc_a),
    .io_wbs_ack(ack_a),
    .io_wbs_adr_s(adr_s_a), .io_wbs_datwr_s(datwr_s_a), .io_wbs_datrd_s(datrd_s_a),
    .io_wbs_we_s(we_s_a), .io_wbs_sel_s(sel_s_a), .io_wbs_stb_s(stb_s_a),
    .io_wbs_ack_s(ack_s_a), .io_wbs_cyc_s(cyc_s_a),
    .err_o(err_a), .dbg_state(st_a)
  );

  wb_mux_n #(
    .N_SLAVES(4),
    .MATCH_ADDR({32'h30003000, 32'h30002000, 32'h30000000, 32'h30000000})
  ) u_ovl (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .io_wbs_adr(adr), .io_wbs_datwr(datwr), .io_wbs_datrd(datrd_b),
    .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb_b), .io_wbs_cyc(cyc_b),
    .io_wbs_ack(ack_b),
    .io_wbs_adr_s(adr_s_b), .io_wbs_datwr_s(datwr_s_b), .io_wbs_datrd_s(datrd_s_b),
    .io_wbs_we_s(we_s_b), .io_wbs_sel_s(sel_s_b), .io_wbs_stb_s(stb_s_b),
    .io_wbs_ack_s(ack_s_b), .io_wbs_cyc_s(cyc_s_b),
    .err_o(err_b), .dbg_state(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req_a(input logic [31:0] a, input logic [31:0] d, input logic w);
    adr = a; datwr = d; we = w; sel = 4'hF; cyc_a = 1'b1; stb_a = 1'b1;
  endtask

  task automatic drop_a();
    cyc_a = 1'b0; stb_a = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; adr = '0; datwr = '0; we = 1'b0; sel = '0;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    ack_s_a = '0; ack_s_b = '0; datrd_s_a = '0; datrd_s_b = '0;
    step(); step();
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_datrd", datrd_a, 32'h0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_stb", 32'(stb_s_a), 32'h0);
    chk("rst_cyc", 32'(cyc_s_a), 32'h0);
    chk("rst_adr_s", adr_s_a[31:0], 32'h0);
    chk("rst_state", 32'(st_a), 32'd0);
    rst = 1'b0;
    step();

    // Read from slave 1. Slave 1 acks two cycles after its strobe; a stray ack from slave 3 is ignored.
    req_a(32'h30001004, 32'h0, 1'b0);
    step();
    chk("rd1_stb", 32'(stb_s_a), 32'h2);
    chk("rd1_cyc", 32'(cyc_s_a), 32'h2);
    chk("rd1_adr_s1", adr_s_a[63:32], 32'h30001004);
    ack_s_a[3] = 1'b1; datrd_s_a[127:96] = 32'hBAD0BAD0;
    step();
    chk("rd1_stray_ack", 32'(ack_a), 32'd0);
    chk("rd1_stb_hold", 32'(stb_s_a), 32'h2);
    ack_s_a[3] = 1'b0;
    step();
    chk("rd1_no_early_ack", 32'(ack_a), 32'd0);
    ack_s_a[1] = 1'b1; datrd_s_a[63:32] = 32'h12345678;
    step();
    chk("rd1_ack", 32'(ack_a), 32'd1);
    chk("rd1_datrd", datrd_a, 32'h12345678);
    chk("rd1_err", 32'(err_a), 32'd0);
    chk("rd1_stb_resp", 32'(stb_s_a), 32'h0);
    ack_s_a[1] = 1'b0; drop_a();
    step();
    chk("rd1_ack_pulse", 32'(ack_a), 32'd0);
    chk("rd1_datrd_hold", datrd_a, 32'h12345678);

    // Write to slave 0.
    req_a(32'h30000010, 32'hA5A5A5A5, 1'b1);
    step();
    chk("wr_stb", 32'(stb_s_a), 32'h1);
    chk("wr_adr_s0", adr_s_a[31:0], 32'h30000010);
    chk("wr_dat_s0", datwr_s_a[31:0], 32'hA5A5A5A5);
    chk("wr_we_s0", 32'(we_s_a[0]), 32'd1);
    chk("wr_sel_s0", 32'(sel_s_a[3:0]), 32'hF);
    chk("wr_no_ack", 32'(ack_a), 32'd0);
    ack_s_a[0] = 1'b1;
    step();
    chk("wr_ack", 32'(ack_a), 32'd1);
    chk("wr_err", 32'(err_a), 32'd0);
    ack_s_a[0] = 1'b0; drop_a();
    step();
    chk("wr_single_ack", 32'(ack_a), 32'd0);

    // Read from an unmapped address.
    req_a(32'h40000000, 32'h0, 1'b0);
    step();
    chk("um_stb", 32'(stb_s_a), 32'h0);
    chk("um_ack", 32'(ack_a), 32'd1);
    chk("um_datrd", datrd_a, 32'hDEADBEEF);
    chk("um_err", 32'(err_a), 32'd1);
    drop_a();
    step();
    chk("um_ack_clr", 32'(ack_a), 32'd0);
    chk("um_err_clr", 32'(err_a), 32'd0);

    // Timeout: slave 2 never acks; the slave strobe stays up for exactly 8 ACTIVE cycles.
    req_a(32'h30002000, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_stb", 32'(stb_s_a), 32'h4);
      chk("to_no_ack", 32'(ack_a), 32'd0);
    end
    step();
    chk("to_stb_drop", 32'(stb_s_a), 32'h0);
    chk("to_ack", 32'(ack_a), 32'd1);
    chk("to_datrd", datrd_a, 32'hDEADBEEF);
    chk("to_err", 32'(err_a), 32'd1);
    drop_a();
    step();

    // A slave 3 ack in the final timer cycle wins over the timeout.
    req_a(32'h30003008, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("tl_stb", 32'(stb_s_a), 32'h8);
    end
    ack_s_a[3] = 1'b1; datrd_s_a[127:96] = 32'hCAFEF00D;
    step();
    chk("tl_ack", 32'(ack_a), 32'd1);
    chk("tl_datrd", datrd_a, 32'hCAFEF00D);
    chk("tl_err", 32'(err_a), 32'd0);
    ack_s_a[3] = 1'b0; drop_a();
    step();

    // Reset asserted while ACTIVE.
    req_a(32'h30001000, 32'h0, 1'b0);
    step();
    chk("rs_stb_pre", 32'(stb_s_a), 32'h2);
    rst = 1'b1; drop_a();
    step();
    chk("rs_stb", 32'(stb_s_a), 32'h0);
    chk("rs_ack", 32'(ack_a), 32'd0);
    chk("rs_datrd", datrd_a, 32'h0);
    chk("rs_state", 32'(st_a), 32'd0);
    rst = 1'b0;
    step();
    chk("rs_ack_after", 32'(ack_a), 32'd0);
    req_a(32'h30001000, 32'h0, 1'b0);
    step();
    chk("rs_rd_stb", 32'(stb_s_a), 32'h2);
    ack_s_a[1] = 1'b1; datrd_s_a[63:32] = 32'h11112222;
    step();
    chk("rs_rd_ack", 32'(ack_a), 32'd1);
    chk("rs_rd_datrd", datrd_a, 32'h11112222);
    ack_s_a[1] = 1'b0; drop_a();
    step();

    // Master abort while ACTIVE, with a slave ack in the same cycle; the abort wins.
    req_a(32'h30000020, 32'h0, 1'b0);
    step();
    chk("ab_stb_pre", 32'(stb_s_a), 32'h1);
    drop_a(); ack_s_a[0] = 1'b1; datrd_s_a[31:0] = 32'h99999999;
    step();
    chk("ab_stb", 32'(stb_s_a), 32'h0);
    chk("ab_ack", 32'(ack_a), 32'd0);
    chk("ab_state", 32'(st_a), 32'd0);
    chk("ab_datrd_hold", datrd_a, 32'h11112222);
    ack_s_a[0] = 1'b0;
    step();
    chk("ab_ack_after", 32'(ack_a), 32'd0);
    req_a(32'h30000020, 32'h0, 1'b0);
    step();
    ack_s_a[0] = 1'b1; datrd_s_a[31:0] = 32'h0BADF00D;
    step();
    chk("ab_rd_ack", 32'(ack_a), 32'd1);
    chk("ab_rd_datrd", datrd_a, 32'h0BADF00D);
    ack_s_a[0] = 1'b0; drop_a();
    step();

    // Overlapping windows on the second instance: only slave 0 is strobed, and slave 1's ack is ignored.
    adr = 32'h30000000; we = 1'b0; sel = 4'hF; cyc_b = 1'b1; stb_b = 1'b1;
    step();
    chk("ov_stb", 32'(stb_s_b), 32'h1);
    ack_s_b[1] = 1'b1; datrd_s_b[63:32] = 32'h77777777;
    step();
    chk("ov_ignore_ack", 32'(ack_b), 32'd0);
    chk("ov_stb_hold", 32'(stb_s_b), 32'h1);
    ack_s_b[1] = 1'b0; ack_s_b[0] = 1'b1; datrd_s_b[31:0] = 32'h55AA55AA;
    step();
    chk("ov_ack", 32'(ack_b), 32'd1);
    chk("ov_datrd", datrd_b, 32'h55AA55AA);
    chk("ov_err", 32'(err_b), 32'd0);
    ack_s_b[0] = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
